// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the default datapath width.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath on the {acc, q} pair.
// Multiply: shift-add, LSB first. Divide: restoring subtract.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Single shift-add or trial-subtract step selected by is_div
    always_comb begin
        sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : '0);
        shifted = {acc_in, q_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // remainder after a successful subtract is below the divisor
        diff    = shifted[WIDTH-1:0] - operand;
        acc_out = '0;
        q_out   = '0;
        if (is_div) begin
            if (fits) begin
                acc_out = diff;
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = shifted[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = sum[WIDTH:1];
            q_out   = {sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Fixed 33-cycle latency; stalls the pipeline on HI/LO or mul/div hazards.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] orig_rs;
    logic             is_div_r;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_op;

    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               sgn;
    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | rd_hi | rd_lo | mthi | mtlo);

    // Operand magnitudes at issue and sign fix-up of the final pair
    always_comb begin
        sgn      = ~op[0];
        mag_rs   = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        mag_rt   = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        prod     = {acc, q};
        prod_fix = neg_q ? -prod : prod;
        quot     = neg_q ? -q : q;
        rem      = neg_r ? -acc : acc;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div (is_div_r),
        .acc_in (acc),
        .q_in   (q),
        .operand(operand),
        .acc_out(acc_nx),
        .q_out  (q_nx)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next-state logic: IDLE -> RUN -> FIX -> IDLE
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = RUN;
            RUN:     if (cnt == LAST) next = FIX;
            FIX:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Datapath, counter and architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            operand     <= '0;
            orig_rs     <= '0;
            is_div_r    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_op      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        acc         <= '0;
                        q           <= mag_rs;
                        operand     <= mag_rt;
                        orig_rs     <= rs_val;
                        is_div_r    <= op[1];
                        neg_q       <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_r       <= sgn & rs_val[WIDTH-1];
                        dbz_op      <= op[1] & (rt_val == '0);
                        div_by_zero <= 1'b0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (dbz_op) begin
                        hi          <= orig_rs;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div_r) begin
                        hi <= rem;
                        lo <= quot;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table + scoreboard,
// plus hand-written stall, reset-abort and MTHI/MTLO sequences.
module tb_muldiv_sequencer;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t r;
        longint sa;
        longint sb2;
        longint p;
        longint qq;
        longint rr;
        logic [63:0] up;
        r.dbz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        if (o == 2'b00) begin
            p = sa * sb2;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (o == 2'b01) begin
            up = {32'b0, a} * {32'b0, b};
            r.hi = up[63:32];
            r.lo = up[31:0];
        end else if (b == 32'd0) begin
            r.hi = a;
            r.lo = '1;
            r.dbz = 1'b1;
        end else if (o == 2'b10) begin
            qq = sa / sb2;
            rr = sa % sb2;
            r.hi = rr[31:0];
            r.lo = qq[31:0];
        end else begin
            r.hi = a % b;
            r.lo = a / b;
        end
        return r;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
        int n;
        exp_t g;
        @(negedge clk);
        start = 1'b1;
        op = o;
        rs_val = a;
        rt_val = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_rise"}, 64'(busy), 64'(1));
        check({name, "_dbz_clear"}, 64'(div_by_zero), 64'(0));
        check({name, "_hold"}, {hi, lo}, {m_hi, m_lo});
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(n), 64'(33));
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            g = sb.pop_front();
            check({name, "_hilo"}, {hi, lo}, {g.hi, g.lo});
            check({name, "_dbz"}, 64'(div_by_zero), 64'(g.dbz));
            m_hi = g.hi;
            m_lo = g.lo;
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        exp_t e;
        int n;
        int bad_stall;
        int bad_hold;

        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        rs_val = '0;
        rt_val = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        rd_hi = 1'b0;
        rd_lo = 1'b0;

        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000007,
                         32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{2'b00, 32'h80000000, 32'h80000000,
                         32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002,
                         32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{2'b11, 32'd100, 32'd7,
                         32'd2, 32'd14, 1'b0});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF,
                         32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{2'b11, 32'h12345678, 32'h00000000,
                         32'h12345678, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE,
                         32'h00000001, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{2'b01, 32'h00010000, 32'h00010000,
                         32'h00000001, 32'h00000000, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFFFFF7, 32'h00000000,
                         32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1});
        for (int i = 0; i < 8; i++) begin
            v.op = 2'(i % 4);
            v.rs = $urandom;
            v.rt = (i == 5) ? 32'd3 : $urandom;
            e = model(v.op, v.rs, v.rt);
            v.hi = e.hi;
            v.lo = e.lo;
            v.dbz = e.dbz;
            vecs.push_back(v);
        end

        @(negedge clk);
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_stall", 64'(stall), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            e.dbz = vecs[i].dbz;
            run_op($sformatf("vec%0d", i), vecs[i].op,
                   vecs[i].rs, vecs[i].rt, e);
        end

        // MULT with MFHI and MTHI held from cycle 5 of the operation
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        rs_val = 32'h00012345;
        rt_val = 32'hFFFF0001;
        sb.push_back(model(2'b00, 32'h00012345, 32'hFFFF0001));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        bad_stall = 0;
        bad_hold = 0;
        while (busy && n < 200) begin
            n++;
            if (n >= 5) begin
                rd_hi = 1'b1;
                mthi = 1'b1;
                wdata = 32'hDEADBEEF;
                #1;
                if (stall !== 1'b1) bad_stall++;
            end
            if (hi !== m_hi) bad_hold++;
            @(negedge clk);
        end
        check("stall_latency", 64'(n), 64'(33));
        check("stall_held", 64'(bad_stall), 64'(0));
        check("stall_hold_hi", 64'(bad_hold), 64'(0));
        #1;
        check("stall_release", 64'(stall), 64'(0));
        e = sb.pop_front();
        check("stall_mfhi", 64'(hi), 64'(e.hi));
        check("stall_lo", 64'(lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
        rd_hi = 1'b0;
        mthi = 1'b0;
        @(negedge clk);
        check("mthi_busy_dropped", 64'(hi), 64'(m_hi));

        // Reset in the middle of a DIV aborts it
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        rs_val = 32'h7654321F;
        rt_val = 32'h00000013;
        sb.push_back(model(2'b10, 32'h7654321F, 32'h00000013));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mtlo = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'(32'hA5A5A5A5));
        check("mtlo_hi", 64'(hi), 64'(0));
        mthi = 1'b1;
        mtlo = 1'b1;
        wdata = 32'h0BADF00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_both", {hi, lo}, {32'h0BADF00D, 32'h0BADF00D});
        m_hi = 32'h0BADF00D;
        m_lo = 32'h0BADF00D;

        // Divide after the abort still behaves normally
        run_op("post_abort", 2'b11, 32'd1000, 32'd33,
               model(2'b11, 32'd1000, 32'd33));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers. Sits in the EX stage beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU from decode and runs each as a fixed-latency iterative operation.
- Stalls the pipeline when a HI/LO access or a new mul/div collides with an operation in flight. Also serves MTHI/MTLO/MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue mul/div this cycle (single-cycle pulse from EX)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- rd_hi  in  1  MFHI in EX
- rd_lo  in  1  MFLO in EX
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- stall  out  1  hold IF/ID/EX this cycle
- div_by_zero  out  1  last divide had divisor 0 (sticky)

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, hi=0, lo=0, busy=0, div_by_zero=0. stall is combinational, so it is 0.
- Reset mid-operation: abort immediately, discard partial results, HI/LO=0.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on start. Latch the operand magnitudes (signed ops take absolute values), the result signs, op, and counter=0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle. counter increments each cycle. Leave RUN when counter == WIDTH-1.
  - FIX: apply signs, write HI/LO, return to IDLE.
- Latency: start sampled at edge E0. busy=1 from after E0 through E33. HI/LO updated at E33, and busy drops at that same edge. That is 33 cycles total, fixed for every op, including divide by zero.
- busy is a registered output: busy = (state != IDLE).
- Multiply result: the 2*WIDTH-bit product. HI = upper half, LO = lower half.
  - MULT negates the full 64-bit product when the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient is negative when the operand signs differ. Remainder takes the dividend's sign.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero: LO=0xFFFFFFFF, HI=rs_val (original dividend, unsigned or signed as given). div_by_zero=1 until the next start, which clears it at E0.
- mthi/mtlo while IDLE: write at the edge. mthi and mtlo in the same cycle write both registers.
- stall = busy & (start | rd_hi | rd_lo | mthi | mtlo).
- While busy, start/mthi/mtlo are ignored; the pipeline re-presents them after the stall. Reads see the final values in the cycle after busy falls.
- start together with mthi/mtlo in IDLE: start wins, and the MT write is dropped. Decode never produces this combination.
- hi/lo outputs hold their old values throughout RUN/FIX until E33.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE/RUN/FIX), WIDTH default.
- One sub-module, muldiv_step: combinational single-iteration datapath (shift-add or restore-subtract on the accumulator/quotient pair), selected by an is_div input.
- FSM, counter, sign fix-up and HI/LO registers live in muldiv_sequencer.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=-3, rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT rs=0x80000000, rt=0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU rs=0x12345678, rt=0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678, div_by_zero=1. Next start clears the flag.
- Start MULT, then hold rd_hi at cycle 5 -> stall=1 through the cycle containing E33, 0 afterwards; MFHI then reads the new HI. mthi during busy -> HI unchanged.
- Start DIV, assert reset at cycle 10 -> busy=0, HI=LO=0 immediately. After release, mtlo 0xA5A5A5A5 in IDLE -> LO=0xA5A5A5A5 next cycle.
